// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-ported register file.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W   = 32;
    localparam int unsigned DEFAULT_NUM_REGS = 32;
    localparam int unsigned DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

    // Architectural zero register: reads 0, ignores writes and issues.
    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending (busy) tracker: issue sets, write clears, reset clears,
// plus a combinational busy lookup for each read port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    parameter int unsigned NUM_RD   = 2,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_issue_en,
    input  logic [ADDR_W-1:0]        i_issue_addr,
    input  logic                     i_clr0_en,
    input  logic [ADDR_W-1:0]        i_clr0_addr,
    input  logic                     i_clr1_en,
    input  logic [ADDR_W-1:0]        i_clr1_addr,
    input  logic [NUM_RD*ADDR_W-1:0] i_ra,
    output logic [NUM_REGS-1:0]      o_busy,
    output logic [NUM_RD-1:0]        o_rd_busy_c
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Issue is applied after the clears so a same-cycle issue wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr0_en) w_busy_nxt[i_clr0_addr] = 1'b0;
        if (i_clr1_en) w_busy_nxt[i_clr1_addr] = 1'b0;
        if (i_issue_en) w_busy_nxt[i_issue_addr] = 1'b1;
        w_busy_nxt[ADDR_W'(ZERO_REG)] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy = r_busy;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
        assign o_rd_busy_c[k] = r_busy[i_ra[k*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/mp_regfile.sv
// Two-write, NUM_RD-read register file with zero register and busy scoreboard.
// Define MP_REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module mp_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    parameter int unsigned NUM_RD   = 2,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd0,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic [NUM_REGS-1:0]      busy,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_we0_eff;
    logic              w_we1_eff;
    logic              w_issue_eff;
    logic [NUM_RD-1:0] w_sb_busy;

    assign w_we0_eff   = we0 && (wa0 != ZERO_A);
    assign w_we1_eff   = we1 && (wa1 != ZERO_A);
    assign w_issue_eff = issue_en && (issue_addr != ZERO_A);

    // Port 1 is written last so it wins on an address collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_we0_eff) r_regs[wa0] <= wd0;
            if (w_we1_eff) r_regs[wa1] <= wd1;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD)
    ) u_scoreboard (
        .i_clk        (clock),
        .i_reset      (reset),
        .i_issue_en   (w_issue_eff),
        .i_issue_addr (issue_addr),
        .i_clr0_en    (w_we0_eff),
        .i_clr0_addr  (wa0),
        .i_clr1_en    (w_we1_eff),
        .i_clr1_addr  (wa1),
        .i_ra         (ra),
        .o_busy       (busy),
        .o_rd_busy_c  (w_sb_busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_read
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_stored;

        assign w_ra     = ra[k*ADDR_W +: ADDR_W];
        assign w_stored = (w_ra == ZERO_A) ? '0 : r_regs[w_ra];

`ifdef MP_REGFILE_BYPASS_EN
        logic w_hit0;
        logic w_hit1;

        // Effective enables already exclude the zero register.
        assign w_hit0 = w_we0_eff && (wa0 == w_ra);
        assign w_hit1 = w_we1_eff && (wa1 == w_ra);

        assign rd[k*DATA_W +: DATA_W] = w_hit1 ? wd1 : (w_hit0 ? wd0 : w_stored);
        assign rd_busy[k]             = w_sb_busy[k] && !(w_hit0 || w_hit1);
`else
        assign rd[k*DATA_W +: DATA_W] = w_stored;
        assign rd_busy[k]             = w_sb_busy[k];
`endif
    end

endmodule

// File: tb/tb_mp_regfile.sv
// Self-checking bench for mp_regfile: directed cases plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_mp_regfile;

    localparam int unsigned DW  = 32;
    localparam int unsigned NR  = 32;
    localparam int unsigned NRD = 2;
    localparam int unsigned AW  = 5;

    localparam int unsigned SDW  = 8;
    localparam int unsigned SNR  = 16;
    localparam int unsigned SNRD = 4;
    localparam int unsigned SAW  = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset;
    logic               we0, we1, issue_en;
    logic [AW-1:0]      wa0, wa1, issue_addr;
    logic [DW-1:0]      wd0, wd1;
    logic [NRD*AW-1:0]  ra;
    logic [NRD*DW-1:0]  rd;
    logic [NR-1:0]      busy;
    logic [NRD-1:0]     rd_busy;

    logic               s_we0, s_we1, s_issue_en;
    logic [SAW-1:0]     s_wa0, s_wa1, s_issue_addr;
    logic [SDW-1:0]     s_wd0, s_wd1;
    logic [SNRD*SAW-1:0] s_ra;
    logic [SNRD*SDW-1:0] s_rd;
    logic [SNR-1:0]     s_busy;
    logic [SNRD-1:0]    s_rd_busy;

    mp_regfile #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) u_dut (
        .clock(clock), .reset(reset),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .ra(ra), .rd(rd),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy(busy), .rd_busy(rd_busy)
    );

    mp_regfile #(.DATA_W(SDW), .NUM_REGS(SNR), .NUM_RD(SNRD)) u_dut_small (
        .clock(clock), .reset(reset),
        .we0(s_we0), .we1(s_we1), .wa0(s_wa0), .wa1(s_wa1), .wd0(s_wd0), .wd1(s_wd1),
        .ra(s_ra), .rd(s_rd),
        .issue_en(s_issue_en), .issue_addr(s_issue_addr),
        .busy(s_busy), .rd_busy(s_rd_busy)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: register contents and pending flags as of the last edge.
    logic [DW-1:0] m_mem  [NR];
    bit            m_busy [NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom);
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we0 && wa0 != 0) begin m_mem[wa0] = wd0; m_busy[wa0] = 1'b0; end
            if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; m_busy[wa1] = 1'b0; end
            if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    end

    // Every-cycle comparison of the main instance against the model.
    always @(negedge clock) begin
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        bit            hit;
        logic [NR-1:0] eb;
        if (chk_en) begin
            for (int k = 0; k < NRD; k++) begin
                a   = ra[k*AW +: AW];
                e   = (a == 0) ? '0 : m_mem[a];
                hit = 1'b0;
`ifdef MP_REGFILE_BYPASS_EN
                if (a != 0 && we1 && wa1 == a) begin
                    e = wd1; hit = 1'b1;
                end else if (a != 0 && we0 && wa0 == a) begin
                    e = wd0; hit = 1'b1;
                end
`endif
                chk($sformatf("model_rd%0d", k), 64'(rd[k*DW +: DW]), 64'(e));
                chk($sformatf("model_rd_busy%0d", k), 64'(rd_busy[k]), 64'(m_busy[a] && !hit));
            end
            for (int i = 0; i < NR; i++) eb[i] = m_busy[i];
            chk("model_busy", 64'(busy), 64'(eb));
        end
    end

    initial begin
        reset = 1'b1;
        we0 = 0; we1 = 0; issue_en = 0;
        wa0 = '0; wa1 = '0; issue_addr = '0; wd0 = '0; wd1 = '0; ra = '0;
        s_we0 = 0; s_we1 = 0; s_issue_en = 0;
        s_wa0 = '0; s_wa1 = '0; s_issue_addr = '0; s_wd0 = '0; s_wd1 = '0; s_ra = '0;
        step();
        step();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state and zero-register write
        ra = {5'd3, 5'd0};
        #1;
        chk("rst_rd0", 64'(rd[31:0]), 64'h0);
        chk("rst_rd1", 64'(rd[63:32]), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_rd_busy", 64'(rd_busy), 64'h0);
        we0 = 1; wa0 = 5'd0; wd0 = 32'hDEADBEEF; ra = {5'd0, 5'd0};
        step();
        we0 = 0;
        #1;
        chk("r0_rd0", 64'(rd[31:0]), 64'h0);
        chk("r0_rd1", 64'(rd[63:32]), 64'h0);

        // Write collision: port 1 wins
        we0 = 1; wa0 = 5'd5; wd0 = 32'h11;
        we1 = 1; wa1 = 5'd5; wd1 = 32'h22;
        ra  = {5'd0, 5'd5};
        step();
        we0 = 0; we1 = 0;
        #1;
        chk("collide_r5", 64'(rd[31:0]), 64'h22);

        // Issue then write two cycles later
        issue_en = 1; issue_addr = 5'd9;
        step();
        issue_en = 0;
        #1;
        chk("busy9_c1", 64'(busy[9]), 64'h1);
        step();
        chk("busy9_c2", 64'(busy[9]), 64'h1);
        we0 = 1; wa0 = 5'd9; wd0 = 32'd64;
        #1;
        chk("busy9_pre_wr", 64'(busy[9]), 64'h1);
        step();
        we0 = 0; ra = {5'd9, 5'd0};
        #1;
        chk("busy9_clr", 64'(busy[9]), 64'h0);
        chk("r9_val", 64'(rd[63:32]), 64'd64);
        issue_en = 1; issue_addr = 5'd9; we1 = 1; wa1 = 5'd9; wd1 = 32'd7;
        step();
        issue_en = 0; we1 = 0;
        #1;
        chk("busy9_issue_wins", 64'(busy[9]), 64'h1);
        chk("rd_busy9", 64'(rd_busy[1]), 64'h1);
        chk("r9_val2", 64'(rd[63:32]), 64'd7);

        // Same-cycle read of a register being written
        we0 = 1; wa0 = 5'd20; wd0 = 32'd5;
        step();
        wd0 = 32'd16; ra = {5'd0, 5'd20};
        #1;
`ifdef MP_REGFILE_BYPASS_EN
        chk("r20_same_cycle", 64'(rd[31:0]), 64'd16);
`else
        chk("r20_same_cycle", 64'(rd[31:0]), 64'd5);
`endif
        step();
        we0 = 0;
        #1;
        chk("r20_next_cycle", 64'(rd[31:0]), 64'd16);

        // Reset discards same-cycle write and issue
        reset = 1; we0 = 1; wa0 = 5'd21; wd0 = 32'd32; issue_en = 1; issue_addr = 5'd21;
        step();
        reset = 0; we0 = 0; issue_en = 0; ra = {5'd20, 5'd21};
        #1;
        chk("r21_after_rst", 64'(rd[31:0]), 64'h0);
        chk("busy21_after_rst", 64'(busy[21]), 64'h0);
        chk("r20_after_rst", 64'(rd[63:32]), 64'h0);

        // Small configuration, all four read ports
        s_we0 = 1; s_wa0 = 4'd15; s_wd0 = 8'hFF;
        step();
        s_we0 = 0; s_ra = {4'd15, 4'd15, 4'd15, 4'd15};
        #1;
        for (int k = 0; k < SNRD; k++) begin
            chk($sformatf("small_rd%0d", k), 64'(s_rd[k*SDW +: SDW]), 64'hFF);
        end
        chk("small_busy", 64'(s_busy), 64'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 59) == 0);
            we0        = 1'($urandom_range(0, 1));
            we1        = 1'($urandom_range(0, 1));
            issue_en   = 1'($urandom_range(0, 1));
            wa0        = pick_addr();
            wa1        = pick_addr();
            issue_addr = pick_addr();
            wd0        = $urandom;
            wd1        = $urandom;
            ra         = {pick_addr(), pick_addr()};
            step();
        end
        reset = 0; we0 = 0; we1 = 0; issue_en = 0;
        step();
        step();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
